// File: rtl/ifetch_unit_pkg.sv
// Shared definitions for the instruction fetch front end: reset PC, MIPS opcode
// fields used for syscall detection, and the prefetch FIFO entry layout.
package ifetch_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    localparam logic [5:0] OP_SPECIAL    = 6'h00;
    localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;

    typedef struct packed {
        logic [31:0] word;
        logic [31:0] pc_plus_4;
    } fifo_entry_t;

    function automatic logic is_syscall(input logic [31:0] word);
        return (word[OP_MSB:OP_LSB] == OP_SPECIAL) &&
               (word[FUNCT_MSB:FUNCT_LSB] == FUNCT_SYSCALL);
    endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Prefetch buffer: synchronous FIFO of {word, pc+4} with push, pop and flush.
// The head reads as zero whenever the buffer is empty.
module ifetch_fifo
    import ifetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [31:0]              i_push_word,
    input  logic [31:0]              i_push_pc4,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [31:0]              o_head_word,
    output logic [31:0]              o_head_pc4,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    fifo_entry_t      r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic        w_do_pop;
    logic        w_do_push;
    logic        w_not_empty;
    fifo_entry_t w_head;

    assign w_not_empty = (r_count != '0);
    assign w_do_pop    = i_pop && w_not_empty;
    // A full buffer may still accept a word in the same cycle its head leaves.
    assign w_do_push   = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

    // NOTE: storage has no reset; occupancy is tracked by r_count alone, so
    // stale contents are never visible and the array can map to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= '{word: i_push_word, pc_plus_4: i_push_pc4};
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_do_push) - CNT_W'(w_do_pop);
        end
    end

    assign w_head      = r_mem[r_rd_ptr];
    assign o_head_word = w_not_empty ? w_head.word      : 32'h0;
    assign o_head_pc4  = w_not_empty ? w_head.pc_plus_4 : 32'h0;
    assign o_count     = r_count;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, prefetch FIFO,
// redirect flush. Optional syscall halt enabled by IFETCH_SYSCALL_HALT_EN.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc_plus_4,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        halted
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      r_pc;
    logic [31:0]      r_rsp_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_discard;

    logic [CNT_W-1:0] w_fifo_count;
    logic [31:0]      w_head_word;
    logic [31:0]      w_head_pc4;
    logic [CNT_W:0]   w_credit_used;
    logic [CNT_W-1:0] w_outstanding_next;
    logic [31:0]      w_target;
    logic             w_pop;
    logic             w_req_fire;
    logic             w_stop;
    logic             w_flush;
    logic             w_push;

    assign w_pop = inst_valid && inst_ready;

    // The word leaving this cycle frees its slot, which keeps single-cycle
    // memory streaming at one instruction per cycle with a two-entry buffer.
    assign w_credit_used = {1'b0, r_outstanding} + {1'b0, w_fifo_count}
                         - (CNT_W+1)'(w_pop);

    assign imem_req_valid = !rst && !redirect_valid && !halted &&
                            (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

`ifdef IFETCH_SYSCALL_HALT_EN
    logic r_halted;

    assign w_stop = w_pop && is_syscall(w_head_word);

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_halted <= 1'b0;
        end else if (w_stop) begin
            r_halted <= 1'b1;
        end
    end

    assign halted = r_halted;
`else
    assign w_stop = 1'b0;
    assign halted = 1'b0;
`endif

    assign w_flush            = redirect_valid || w_stop;
    assign w_push             = imem_rsp_valid && (r_discard == '0) && !w_flush;
    assign w_outstanding_next = r_outstanding + CNT_W'(w_req_fire) - CNT_W'(imem_rsp_valid);
    assign w_target           = redirect_target & 32'hFFFF_FFFC;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC & 32'hFFFF_FFFC;
            r_rsp_pc      <= RESET_PC & 32'hFFFF_FFFC;
            r_outstanding <= '0;
            r_discard     <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;

            if (redirect_valid) begin
                r_pc     <= w_target;
                r_rsp_pc <= w_target;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
            end

            // Everything still in flight after this cycle belongs to the old stream.
            if (w_flush) begin
                r_discard <= w_outstanding_next;
            end else if (imem_rsp_valid && (r_discard != '0)) begin
                r_discard <= r_discard - CNT_W'(1);
            end
        end
    end

    ifetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_word (imem_rsp_data),
        .i_push_pc4  (r_rsp_pc + 32'd4),
        .i_pop       (w_pop),
        .i_flush     (w_flush),
        .o_head_word (w_head_word),
        .o_head_pc4  (w_head_pc4),
        .o_count     (w_fifo_count)
    );

    assign inst_valid     = (w_fifo_count != '0);
    assign inst_data      = w_head_word;
    assign inst_pc_plus_4 = w_head_pc4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: streaming, backpressure, redirects, PC wrap
// and the syscall halt option, against a fixed-latency memory model.
module tb_ifetch_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: RESET_PC = 0, memory latency selectable.
    logic        a_req_valid;
    logic        a_req_ready  = 1'b1;
    logic [31:0] a_req_addr;
    logic        a_rsp_valid;
    logic [31:0] a_rsp_data;
    logic        a_inst_valid;
    logic        a_inst_ready = 1'b0;
    logic [31:0] a_inst_data;
    logic [31:0] a_inst_pc4;
    logic        a_redirect   = 1'b0;
    logic [31:0] a_target     = 32'h0;
    logic        a_halted;

    // Instance B: RESET_PC near the top of the address space.
    logic        b_req_valid;
    logic [31:0] b_req_addr;
    logic        b_rsp_valid = 1'b0;
    logic [31:0] b_rsp_data  = 32'h0;
    logic        b_inst_valid;
    logic [31:0] b_inst_data;
    logic [31:0] b_inst_pc4;
    logic        b_halted;

    int          lat      = 1;
    logic [31:0] sys_addr = 32'hFFFF_FFFF;
    logic [3:1]  pv       = '0;
    logic [31:0] pd [1:3];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == sys_addr) ? 32'h0000_000C : {8'hA5, a[23:0]};
    endfunction

    ifetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut_a (
        .clk(clk), .rst(rst),
        .imem_req_valid(a_req_valid), .imem_req_ready(a_req_ready), .imem_req_addr(a_req_addr),
        .imem_rsp_valid(a_rsp_valid), .imem_rsp_data(a_rsp_data),
        .inst_valid(a_inst_valid), .inst_ready(a_inst_ready),
        .inst_data(a_inst_data), .inst_pc_plus_4(a_inst_pc4),
        .redirect_valid(a_redirect), .redirect_target(a_target),
        .halted(a_halted)
    );

    ifetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_b (
        .clk(clk), .rst(rst),
        .imem_req_valid(b_req_valid), .imem_req_ready(1'b1), .imem_req_addr(b_req_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .inst_valid(b_inst_valid), .inst_ready(1'b1),
        .inst_data(b_inst_data), .inst_pc_plus_4(b_inst_pc4),
        .redirect_valid(1'b0), .redirect_target(32'h0),
        .halted(b_halted)
    );

    // Fixed-latency in-order memory; reset together with the fetch unit.
    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv[1] <= a_req_valid && a_req_ready;
            pv[2] <= pv[1];
            pv[3] <= pv[2];
        end
        pd[1] <= mem_word(a_req_addr);
        pd[2] <= pd[1];
        pd[3] <= pd[2];
        b_rsp_valid <= !rst && b_req_valid;
        b_rsp_data  <= mem_word(b_req_addr);
    end
    assign a_rsp_valid = pv[lat];
    assign a_rsp_data  = pd[lat];

    task automatic do_reset(input int l);
        rst          = 1'b1;
        lat          = l;
        a_inst_ready = 1'b0;
        a_redirect   = 1'b0;
        a_target     = 32'h0;
        a_req_ready  = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        lat = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b expected 0", a_req_valid); end
        checks++; if (a_inst_valid !== 1'b0) begin errors++; $display("FAIL reset_inst_valid got %b expected 0", a_inst_valid); end
        checks++; if (a_inst_data !== 32'h0 || a_inst_pc4 !== 32'h0) begin errors++; $display("FAIL reset_inst_zero got data=%h pc4=%h expected 0/0", a_inst_data, a_inst_pc4); end
        checks++; if (a_halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b expected 0", a_halted); end
        checks++; if (b_req_valid !== 1'b0 || b_req_addr !== 32'hFFFF_FFF8) begin errors++; $display("FAIL reset_b_pc got valid=%b addr=%h expected 0/fffffff8", b_req_valid, b_req_addr); end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h0) begin errors++; $display("FAIL reset_first_req got valid=%b addr=%h expected 1/00000000", a_req_valid, a_req_addr); end
    endtask

    task automatic test_stream();
        do_reset(1);
        a_inst_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            checks++;
            if (a_req_valid !== 1'b1 || a_req_addr !== 32'(4 * (c - 1))) begin
                errors++; $display("FAIL stream_req c=%0d got valid=%b addr=%h expected 1/%h", c, a_req_valid, a_req_addr, 32'(4 * (c - 1)));
            end
            checks++;
            if (c >= 3) begin
                if (a_inst_valid !== 1'b1 || a_inst_pc4 !== 32'(4 * (c - 2)) || a_inst_data !== mem_word(32'(4 * (c - 3)))) begin
                    errors++; $display("FAIL stream_inst c=%0d got valid=%b pc4=%h data=%h expected 1/%h/%h", c, a_inst_valid, a_inst_pc4, a_inst_data, 32'(4 * (c - 2)), mem_word(32'(4 * (c - 3))));
                end
            end else if (a_inst_valid !== 1'b0 || a_inst_data !== 32'h0 || a_inst_pc4 !== 32'h0) begin
                errors++; $display("FAIL stream_empty c=%0d got valid=%b data=%h pc4=%h expected 0/0/0", c, a_inst_valid, a_inst_data, a_inst_pc4);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int          fires;
        int          pops;
        logic [31:0] exp_pc4;
        logic [31:0] fire_addr [2];
        fire_addr[0] = 32'hDEAD_BEEF;
        fire_addr[1] = 32'hDEAD_BEEF;
        do_reset(1);
        fires = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_req_valid && a_req_ready) begin
                if (fires < 2) fire_addr[fires] = a_req_addr;
                fires++;
            end
            if (c < 10) begin @(posedge clk); #1; end
        end
        checks++; if (fires != 2) begin errors++; $display("FAIL bp_req_count got %0d expected 2", fires); end
        checks++; if (fire_addr[0] !== 32'h0 || fire_addr[1] !== 32'h4) begin errors++; $display("FAIL bp_req_addrs got %h %h expected 00000000 00000004", fire_addr[0], fire_addr[1]); end
        checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_blocked got %b expected 0", a_req_valid); end
        checks++; if (a_inst_valid !== 1'b1 || a_inst_data !== mem_word(32'h0) || a_inst_pc4 !== 32'h4) begin errors++; $display("FAIL bp_head got valid=%b data=%h pc4=%h expected 1/%h/00000004", a_inst_valid, a_inst_data, a_inst_pc4, mem_word(32'h0)); end
        @(posedge clk); #1;
        a_inst_ready = 1'b1;
        exp_pc4 = 32'h4;
        pops = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (a_inst_valid && a_inst_ready) begin
                checks++;
                if (a_inst_pc4 !== exp_pc4 || a_inst_data !== mem_word(exp_pc4 - 32'd4)) begin
                    errors++; $display("FAIL bp_order got pc4=%h data=%h expected %h/%h", a_inst_pc4, a_inst_data, exp_pc4, mem_word(exp_pc4 - 32'd4));
                end
                exp_pc4 = exp_pc4 + 32'd4;
                pops++;
            end
            @(posedge clk); #1;
        end
        checks++; if (pops != 12) begin errors++; $display("FAIL bp_release_rate got %0d pops expected 12", pops); end
    endtask

    task automatic test_redirect_inflight();
        int          fire_cyc;
        int          pop_cyc;
        logic [31:0] fire_a;
        logic [31:0] pop_pc4;
        logic [31:0] pop_data;
        fire_a = 32'hDEAD_BEEF; pop_pc4 = 32'hDEAD_BEEF; pop_data = 32'hDEAD_BEEF;
        fire_cyc = -1; pop_cyc = -1;
        do_reset(3);
        a_inst_ready = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            a_redirect = (c == 3);
            a_target   = 32'h0000_0100;
            @(negedge clk);
            if (c <= 2) begin
                checks++;
                if (a_req_valid !== 1'b1 || a_req_addr !== 32'(4 * (c - 1))) begin
                    errors++; $display("FAIL rdi_req c=%0d got valid=%b addr=%h expected 1/%h", c, a_req_valid, a_req_addr, 32'(4 * (c - 1)));
                end
            end
            if (c == 3) begin
                checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL rdi_no_req_on_redirect got %b expected 0", a_req_valid); end
            end
            if (c > 3 && fire_cyc < 0 && a_req_valid && a_req_ready) begin fire_cyc = c; fire_a = a_req_addr; end
            if (c > 3 && pop_cyc < 0 && a_inst_valid && a_inst_ready) begin pop_cyc = c; pop_pc4 = a_inst_pc4; pop_data = a_inst_data; end
            @(posedge clk); #1;
        end
        a_redirect = 1'b0;
        checks++; if (fire_cyc != 5 || fire_a !== 32'h100) begin errors++; $display("FAIL rdi_target_req got cycle=%0d addr=%h expected 5/00000100", fire_cyc, fire_a); end
        checks++; if (pop_cyc != 9) begin errors++; $display("FAIL rdi_first_inst_cycle got %0d expected 9", pop_cyc); end
        checks++; if (pop_pc4 !== 32'h104 || pop_data !== mem_word(32'h100)) begin errors++; $display("FAIL rdi_first_inst got pc4=%h data=%h expected 00000104/%h", pop_pc4, pop_data, mem_word(32'h100)); end
    endtask

    task automatic test_redirect_pop();
        do_reset(1);
        a_inst_ready = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            a_redirect = (c == 5);
            a_target   = 32'h0000_0102;
            @(negedge clk);
            if (c == 5) begin
                checks++; if (a_inst_valid !== 1'b1 || a_inst_pc4 !== 32'hC) begin errors++; $display("FAIL rdp_pop_same_cycle got valid=%b pc4=%h expected 1/0000000c", a_inst_valid, a_inst_pc4); end
                checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL rdp_no_req got %b expected 0", a_req_valid); end
            end
            if (c == 6) begin
                checks++; if (a_inst_valid !== 1'b0) begin errors++; $display("FAIL rdp_flushed got %b expected 0", a_inst_valid); end
                checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h100) begin errors++; $display("FAIL rdp_target_req got valid=%b addr=%h expected 1/00000100", a_req_valid, a_req_addr); end
            end
            if (c == 7) begin
                checks++; if (a_inst_valid !== 1'b0 || a_req_addr !== 32'h104) begin errors++; $display("FAIL rdp_c7 got valid=%b addr=%h expected 0/00000104", a_inst_valid, a_req_addr); end
            end
            if (c >= 8) begin
                checks++;
                if (a_inst_valid !== 1'b1 || a_inst_pc4 !== 32'h104 + 32'(4 * (c - 8)) || a_inst_data !== mem_word(32'h100 + 32'(4 * (c - 8)))) begin
                    errors++; $display("FAIL rdp_target_inst c=%0d got valid=%b pc4=%h data=%h expected 1/%h", c, a_inst_valid, a_inst_pc4, a_inst_data, 32'h104 + 32'(4 * (c - 8)));
                end
            end
            @(posedge clk); #1;
        end
        a_redirect = 1'b0;
    endtask

    task automatic test_reset_pc_wrap();
        do_reset(1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (b_req_valid !== 1'b1 || b_req_addr !== 32'hFFFF_FFF8 + 32'(4 * (c - 1))) begin
                errors++; $display("FAIL wrap_req c=%0d got valid=%b addr=%h expected 1/%h", c, b_req_valid, b_req_addr, 32'hFFFF_FFF8 + 32'(4 * (c - 1)));
            end
            if (c == 3) begin
                checks++; if (b_inst_valid !== 1'b1 || b_inst_pc4 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc4_c3 got valid=%b pc4=%h expected 1/fffffffc", b_inst_valid, b_inst_pc4); end
            end
            if (c == 4) begin
                checks++; if (b_inst_valid !== 1'b1 || b_inst_pc4 !== 32'h0 || b_inst_data !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_pc4_c4 got valid=%b pc4=%h data=%h expected 1/00000000/%h", b_inst_valid, b_inst_pc4, b_inst_data, mem_word(32'hFFFF_FFFC)); end
            end
            @(posedge clk); #1;
        end
    endtask

`ifdef IFETCH_SYSCALL_HALT_EN
    task automatic test_syscall_halt();
        sys_addr = 32'h8;
        do_reset(1);
        a_inst_ready = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            a_redirect = (c == 10);
            a_target   = 32'h0000_0040;
            @(negedge clk);
            if (c == 5) begin
                checks++; if (a_inst_data !== 32'h0000_000C || a_halted !== 1'b0) begin errors++; $display("FAIL sys_pop got data=%h halted=%b expected 0000000c/0", a_inst_data, a_halted); end
            end
            if (c >= 6 && c <= 9) begin
                checks++; if (a_halted !== 1'b1 || a_req_valid !== 1'b0 || a_inst_valid !== 1'b0) begin errors++; $display("FAIL sys_halted c=%0d got halted=%b req=%b inst=%b expected 1/0/0", c, a_halted, a_req_valid, a_inst_valid); end
            end
            if (c == 10) begin
                checks++; if (a_req_valid !== 1'b0) begin errors++; $display("FAIL sys_redirect_cycle got req=%b expected 0", a_req_valid); end
            end
            if (c == 11) begin
                checks++; if (a_halted !== 1'b0 || a_req_valid !== 1'b1 || a_req_addr !== 32'h40) begin errors++; $display("FAIL sys_resume got halted=%b req=%b addr=%h expected 0/1/00000040", a_halted, a_req_valid, a_req_addr); end
            end
            if (c == 13) begin
                checks++; if (a_inst_valid !== 1'b1 || a_inst_pc4 !== 32'h44) begin errors++; $display("FAIL sys_resume_inst got valid=%b pc4=%h expected 1/00000044", a_inst_valid, a_inst_pc4); end
            end
            @(posedge clk); #1;
        end
        a_redirect = 1'b0;
        sys_addr   = 32'hFFFF_FFFF;
    endtask
`else
    task automatic test_syscall_passthrough();
        sys_addr = 32'h8;
        do_reset(1);
        a_inst_ready = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++; if (a_inst_data !== 32'h0000_000C || a_halted !== 1'b0) begin errors++; $display("FAIL sys_pass_pop got data=%h halted=%b expected 0000000c/0", a_inst_data, a_halted); end
            end
            if (c == 6) begin
                checks++; if (a_halted !== 1'b0 || a_inst_valid !== 1'b1 || a_inst_pc4 !== 32'h10) begin errors++; $display("FAIL sys_pass_next got halted=%b valid=%b pc4=%h expected 0/1/00000010", a_halted, a_inst_valid, a_inst_pc4); end
                checks++; if (a_req_valid !== 1'b1 || a_req_addr !== 32'h14) begin errors++; $display("FAIL sys_pass_req got valid=%b addr=%h expected 1/00000014", a_req_valid, a_req_addr); end
            end
            @(posedge clk); #1;
        end
        sys_addr = 32'hFFFF_FFFF;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_inflight();
        test_redirect_pop();
        test_reset_pc_wrap();
`ifdef IFETCH_SYSCALL_HALT_EN
        test_syscall_halt();
`else
        test_syscall_passthrough();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
